// File: rtl/rptr_empty_prog.sv
// ---------------------------------------------------------------------------
// rptr_empty_prog
//
// Read-domain pointer and status controller for an asynchronous FIFO. It lives
// in the rclk domain, between the write-pointer synchroniser and the read port
// of the dual-port memory. It keeps a binary read pointer and publishes a Gray
// copy of it. The Gray copy goes back to the write domain for synchronisation.
//
// The block also reports the following status, all registered:
//   - an empty flag
//   - an almost-empty flag with a programmable threshold
//   - a fill level
//   - a sticky underflow error
// A synchronous flush discards everything that is currently visible to the
// reader.
//
// Because the synchronised write pointer lags the real one, the level and the
// flags are pessimistic. They can under-report stored data but never
// over-report it.
//
// Parameters
//   ADDRSIZE        memory address width; depth = 2**ADDRSIZE, pointers ADDRSIZE+1 bits
//
// Ports
//   rclk            in   read-domain clock, all state changes on posedge
//   rrst_n          in   asynchronous active-low reset
//   rinc            in   pop request, honoured only while not empty
//   rflush          in   jump the read pointer to the synchronised write pointer
//   rae_thresh      in   almost-empty threshold in entries
//   rerr_clr        in   clear request for the sticky underflow flag
//   rq2_wptr        in   Gray write pointer already synchronised into rclk
//   raddr           out  memory read address (low bits of the binary read pointer)
//   rptr            out  registered Gray read pointer
//   rempty          out  registered empty flag
//   raempty         out  registered almost-empty flag
//   rlevel          out  registered fill level, 0 .. 2**ADDRSIZE
//   rerr_underflow  out  sticky flag: a pop was attempted while empty
// ---------------------------------------------------------------------------
module rptr_empty_prog #(
    parameter int ADDRSIZE = 9
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic                rflush,
    input  logic [ADDRSIZE-1:0] rae_thresh,
    input  logic                rerr_clr,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                rerr_underflow
);

    // Registered state and its next-state values
    logic [ADDRSIZE:0] rbin_q,    rbin_d;
    logic [ADDRSIZE:0] rgray_q,   rgray_d;
    logic              rempty_q,  rempty_d;
    logic              raempty_q, raempty_d;
    logic [ADDRSIZE:0] rlevel_q,  rlevel_d;
    logic              rerr_q,    rerr_d;

    logic [ADDRSIZE:0] wbinSync;
    logic              pop;
    logic              underflow;

    // Convert the synchronised Gray write pointer to binary.
    // Each binary bit is the XOR of all Gray bits from the MSB down to that
    // position, so the conversion runs as a prefix chain starting at the top.
    always_comb begin
        wbinSync = '0;
        wbinSync[ADDRSIZE] = rq2_wptr[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            wbinSync[i] = wbinSync[i+1] ^ rq2_wptr[i];
        end
    end

    // Decide between pop, flush and hold, and build every next-state value.
    //
    // Flush has priority over rinc: during a flush nothing is popped and no
    // underflow is flagged. The empty and level values are computed from the
    // next pointer, so popping the last word raises rempty on that same edge.
    //
    // For the error flag, a new underflow beats a simultaneous clear, so that
    // an error raised in the same cycle as the clear is not lost.
    always_comb begin
        pop       = rinc & ~rempty_q & ~rflush;
        underflow = rinc &  rempty_q & ~rflush;

        rbin_d = rbin_q;
        if (rflush) begin
            rbin_d = wbinSync;
        end else if (pop) begin
            rbin_d = rbin_q + {{ADDRSIZE{1'b0}}, 1'b1};
        end

        rgray_d   = (rbin_d >> 1) ^ rbin_d;
        rempty_d  = (rgray_d == rq2_wptr);
        rlevel_d  = wbinSync - rbin_d;
        raempty_d = (rlevel_d <= {1'b0, rae_thresh});

        rerr_d = rerr_q;
        if (underflow) begin
            rerr_d = 1'b1;
        end else if (rerr_clr) begin
            rerr_d = 1'b0;
        end
    end

    // State register. Reset puts the block in the empty state with no error.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q    <= '0;
            rgray_q   <= '0;
            rempty_q  <= 1'b1;
            raempty_q <= 1'b1;
            rlevel_q  <= '0;
            rerr_q    <= 1'b0;
        end else begin
            rbin_q    <= rbin_d;
            rgray_q   <= rgray_d;
            rempty_q  <= rempty_d;
            raempty_q <= raempty_d;
            rlevel_q  <= rlevel_d;
            rerr_q    <= rerr_d;
        end
    end

    assign raddr          = rbin_q[ADDRSIZE-1:0];
    assign rptr           = rgray_q;
    assign rempty         = rempty_q;
    assign raempty        = raempty_q;
    assign rlevel         = rlevel_q;
    assign rerr_underflow = rerr_q;

endmodule

// File: tb/tb_rptr_empty_prog.sv
// ---------------------------------------------------------------------------
// tb_rptr_empty_prog
//
// Self-checking bench for rptr_empty_prog, built with ADDRSIZE=4 (depth 16).
//
// The reference model works in plain integer counts: a write count and a read
// count, both modulo 32. The fill level is their difference. The flags follow
// from that level, and flush and underflow behaviour is expressed directly in
// those terms.
//
// All DUT outputs are packed into one vector and compared against the vector
// the model expects.
// ---------------------------------------------------------------------------
module tb_rptr_empty_prog;

    localparam int AW = 4;

    logic          rclk;
    logic          rrst_n;
    logic          rinc;
    logic          rflush;
    logic [AW-1:0] rae_thresh;
    logic          rerr_clr;
    logic [AW:0]   rq2_wptr;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic          raempty;
    logic [AW:0]   rlevel;
    logic          rerr_underflow;

    rptr_empty_prog #(.ADDRSIZE(AW)) dut (
        .rclk           (rclk),
        .rrst_n         (rrst_n),
        .rinc           (rinc),
        .rflush         (rflush),
        .rae_thresh     (rae_thresh),
        .rerr_clr       (rerr_clr),
        .rq2_wptr       (rq2_wptr),
        .raddr          (raddr),
        .rptr           (rptr),
        .rempty         (rempty),
        .raempty        (raempty),
        .rlevel         (rlevel),
        .rerr_underflow (rerr_underflow)
    );

    // Free-running read clock, period 10
    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    // Observed outputs packed as {rptr, raddr, rempty, raempty, rlevel, rerr}
    logic [16:0] obsVec;
    assign obsVec = {rptr, raddr, rempty, raempty, rlevel, rerr_underflow};

    int passCount  = 0;
    int checkCount = 0;

    // Reference model state: counts modulo 32
    int mW   = 0;
    int mRd  = 0;
    int mThr = 0;
    int mLvl = 0;
    bit mEmpty = 1'b1;
    bit mAe    = 1'b1;
    bit mErr   = 1'b0;

    // Gray encoding of a 5-bit binary count
    function automatic logic [4:0] bin2gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Output vector the model expects right now
    function automatic logic [16:0] expVec();
        logic [4:0] rd5;
        logic [4:0] lv5;
        rd5 = 5'(mRd);
        lv5 = 5'(mLvl);
        return {bin2gray(rd5), rd5[3:0], mEmpty, mAe, lv5, mErr};
    endfunction

    // Return the model to its reset state
    task automatic modelReset();
        mRd    = 0;
        mLvl   = 0;
        mEmpty = 1'b1;
        mAe    = 1'b1;
        mErr   = 1'b0;
    endtask

    // Drive one cycle of inputs, wait for the edge and advance the model.
    // The task returns 1 time unit after the edge, away from the active edge.
    task automatic applyStimulus(input logic inc, input logic flush, input logic clr);
        bit pop;
        bit under;
        rinc       = inc;
        rflush     = flush;
        rerr_clr   = clr;
        rq2_wptr   = bin2gray(5'(mW));
        rae_thresh = 4'(mThr);
        @(posedge rclk);
        pop   = inc && !mEmpty && !flush;
        under = inc &&  mEmpty && !flush;
        if (flush) mRd = mW;
        else if (pop) mRd = (mRd + 1) % 32;
        if (under) mErr = 1'b1;
        else if (clr) mErr = 1'b0;
        mLvl   = (mW - mRd + 32) % 32;
        mEmpty = (mLvl == 0);
        mAe    = (mLvl <= mThr);
        #1;
    endtask

    // Hold reset with a pop request active; every output must sit at its reset value
    task automatic test_reset();
        rrst_n     = 1'b0;
        rinc       = 1'b1;
        rflush     = 1'b0;
        rerr_clr   = 1'b0;
        rae_thresh = '0;
        rq2_wptr   = '0;
        mW         = 0;
        modelReset();
        repeat (3) @(posedge rclk);
        #1;
        checkCount++;
        if (obsVec !== expVec())
            $display("[TB] FAIL reset: got %h expected %h", obsVec, expVec());
        else
            passCount++;
        @(negedge rclk);
        rrst_n = 1'b1;
        rinc   = 1'b0;
    endtask

    // Five words visible, threshold 2: drain them one pop at a time
    task automatic test_drain();
        mW   = 5;
        mThr = 2;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkCount++;
        if (obsVec !== expVec())
            $display("[TB] FAIL drain_fill: got %h expected %h", obsVec, expVec());
        else
            passCount++;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkCount++;
            if (obsVec !== expVec())
                $display("[TB] FAIL drain_pop%0d: got %h expected %h", i, obsVec, expVec());
            else
                passCount++;
        end
    endtask

    // Read pointer at 16, write pointer at 0 (32 mod 32): full. Then drain all 16.
    task automatic test_wrap();
        mW = 16;
        applyStimulus(1'b0, 1'b1, 1'b0);
        mW = 0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkCount++;
        if (obsVec !== expVec() || rlevel !== 5'd16)
            $display("[TB] FAIL wrap_full: got %h expected %h", obsVec, expVec());
        else
            passCount++;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkCount++;
            if (obsVec !== expVec())
                $display("[TB] FAIL wrap_pop%0d: got %h expected %h", i, obsVec, expVec());
            else
                passCount++;
        end
    endtask

    // Pop while empty: error is set, persists, survives a same-cycle clear, then clears
    task automatic test_underflow();
        logic [4:0] ptrBefore;
        ptrBefore = rptr;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkCount++;
        if (obsVec !== expVec() || rptr !== ptrBefore)
            $display("[TB] FAIL underflow_set: got %h expected %h", obsVec, expVec());
        else
            passCount++;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkCount++;
        if (obsVec !== expVec())
            $display("[TB] FAIL underflow_sticky: got %h expected %h", obsVec, expVec());
        else
            passCount++;
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkCount++;
        if (obsVec !== expVec())
            $display("[TB] FAIL underflow_setwins: got %h expected %h", obsVec, expVec());
        else
            passCount++;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkCount++;
        if (obsVec !== expVec())
            $display("[TB] FAIL underflow_clear: got %h expected %h", obsVec, expVec());
        else
            passCount++;
    endtask

    // Nine words visible and the error set; flush together with rinc empties the FIFO
    task automatic test_flush();
        applyStimulus(1'b1, 1'b0, 1'b0);
        mW = (mRd + 9) % 32;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkCount++;
        if (obsVec !== expVec())
            $display("[TB] FAIL flush_fill: got %h expected %h", obsVec, expVec());
        else
            passCount++;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkCount++;
        if (obsVec !== expVec())
            $display("[TB] FAIL flush_edge: got %h expected %h", obsVec, expVec());
        else
            passCount++;
        applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    // Random traffic: the write count only advances, and never by more than the free space
    task automatic test_random();
        int lvl;
        int add;
        for (int i = 0; i < 400; i++) begin
            lvl = (mW - mRd + 32) % 32;
            add = $urandom_range(0, 3);
            if (add > 16 - lvl) add = 16 - lvl;
            if ($urandom_range(0, 40) == 0) add = 16 - lvl;
            mW   = (mW + add) % 32;
            mThr = $urandom_range(0, 15);
            applyStimulus(1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 7) == 0));
            checkCount++;
            if (obsVec !== expVec())
                $display("[TB] FAIL random%0d: got %h expected %h", i, obsVec, expVec());
            else
                passCount++;
        end
    endtask

    // Level 7 while draining, then reset asserted between edges
    task automatic test_async_reset();
        mThr = 3;
        mW   = (mRd + 9) % 32;
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkCount++;
        if (obsVec !== expVec() || rlevel !== 5'd7)
            $display("[TB] FAIL async_pre: got %h expected %h", obsVec, expVec());
        else
            passCount++;
        #2;
        rrst_n = 1'b0;
        #1;
        modelReset();
        checkCount++;
        if (obsVec !== expVec())
            $display("[TB] FAIL async_reset: got %h expected %h", obsVec, expVec());
        else
            passCount++;
        rinc     = 1'b0;
        mW       = 0;
        rq2_wptr = '0;
        @(negedge rclk);
        rrst_n = 1'b1;
        mW     = 3;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkCount++;
        if (obsVec !== expVec())
            $display("[TB] FAIL async_release: got %h expected %h", obsVec, expVec());
        else
            passCount++;
    endtask

    initial begin
        test_reset();
        test_drain();
        test_wrap();
        test_underflow();
        test_flush();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
